idct8_skew_feeder: RTL and testbench

Input feeder for the systolic 8-point IDCT row chain. It accepts one 8-coefficient row per cycle and skews the coefficients onto the chain's `d_in_1..d_in_8` lanes, so that lane k reaches the first IDCT stage exactly k−1 cycles after lane 1. It also drives the pass-dependent rounding `add`/`shift` pair in step with each row, and emits a valid/row/last tag aligned with the chain's `d_out`.

---
 rtl/idct8_skew_feeder_pkg.sv | 31 +++
 rtl/idct8_delay_line.sv | 39 +++
 rtl/idct8_skew_feeder.sv | 172 +++++++++++++++++
 tb/tb_idct8_skew_feeder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/idct8_skew_feeder_pkg.sv
// Shared constants and types for the IDCT row-chain input feeder.
// Pass rounding constants, latencies and the result tag carried alongside each row.
package idct_pkg;

   localparam int W = 25;
   localparam int N = 8;

   localparam logic [3:0]  PASS0_SHIFT = 4'd7;
   localparam logic [24:0] PASS0_ADD   = 25'd64;
   localparam logic [3:0]  PASS1_SHIFT = 4'd12;
   localparam logic [24:0] PASS1_ADD   = 25'd2048;

   // Edges from accept until the tag appears beside the chain's d_out.
   localparam int OUT_LATENCY = 9;
   localparam int PASS_DEPTH  = 8;

   typedef struct packed {
      logic       valid;
      logic [2:0] row;
      logic       last;
   } tag_t;

   function automatic logic [3:0] pass_shift(input logic pass);
      return pass ? PASS1_SHIFT : PASS0_SHIFT;
   endfunction

   function automatic logic [24:0] pass_add(input logic pass);
      return pass ? PASS1_ADD : PASS0_ADD;
   endfunction

endpackage

// File: rtl/idct8_delay_line.sv
// Fixed-depth register delay line with asynchronous active-low clear.
// Output is the last stage, so a value entering at edge E is visible after edge E+DEPTH-1.
module idct8_delay_line #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   // Shift: new sample into stage 0, every other stage takes its predecessor.
   always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/idct8_skew_feeder.sv
// Skews one 8-coefficient row per cycle onto the IDCT chain lanes and tracks
// per-row rounding constants and the output tag in step with the chain.
module idct8_skew_feeder #(
   parameter int W = idct_pkg::W,
   parameter int N = idct_pkg::N
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_pass,
   input  logic signed [W-1:0] in_row_1,
   input  logic signed [W-1:0] in_row_2,
   input  logic signed [W-1:0] in_row_3,
   input  logic signed [W-1:0] in_row_4,
   input  logic signed [W-1:0] in_row_5,
   input  logic signed [W-1:0] in_row_6,
   input  logic signed [W-1:0] in_row_7,
   input  logic signed [W-1:0] in_row_8,
   output logic signed [W-1:0] d_in_1,
   output logic signed [W-1:0] d_in_2,
   output logic signed [W-1:0] d_in_3,
   output logic signed [W-1:0] d_in_4,
   output logic signed [W-1:0] d_in_5,
   output logic signed [W-1:0] d_in_6,
   output logic signed [W-1:0] d_in_7,
   output logic signed [W-1:0] d_in_8,
   output logic [24:0]         add,
   output logic [3:0]          shift,
   output logic                out_valid,
   output logic [2:0]          out_row,
   output logic                out_last
);

   import idct_pkg::*;

   logic        rdy_q, rdy_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        last_pass_q, last_pass_d;
   logic [24:0] add_q, add_d;
   logic [3:0]  shift_q, shift_d;
   tag_t        out_q, out_d;

   logic        acc_s;
   logic [2:0]  row_idx_s;
   tag_t        tag_s, tag_dly_s;
   logic [1:0]  pass_in_s, pass_dly_s;
   logic [W-1:0] row_s      [N];
   logic [W-1:0] lane_in_s  [N];
   logic [W-1:0] lane_out_s [N];

   assign row_s[0] = in_row_1;
   assign row_s[1] = in_row_2;
   assign row_s[2] = in_row_3;
   assign row_s[3] = in_row_4;
   assign row_s[4] = in_row_5;
   assign row_s[5] = in_row_6;
   assign row_s[6] = in_row_7;
   assign row_s[7] = in_row_8;

   assign acc_s = in_valid & rdy_q;

   // Bubble slots push zeros so the chain computes 0 for them.
   always_comb begin
      for (int k = 0; k < N; k++) begin
         if (acc_s) begin
            lane_in_s[k] = row_s[k];
         end else begin
            lane_in_s[k] = '0;
         end
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_lane
      idct8_delay_line #(.DEPTH(k + 1), .WIDTH(W)) u_lane (
         .clk   (clk),
         .rst_n (reset),
         .din   (lane_in_s[k]),
         .dout  (lane_out_s[k])
      );
   end

   assign pass_in_s = {acc_s, in_pass};

   idct8_delay_line #(.DEPTH(PASS_DEPTH), .WIDTH(2)) u_pass (
      .clk   (clk),
      .rst_n (reset),
      .din   (pass_in_s),
      .dout  (pass_dly_s)
   );

   idct8_delay_line #(.DEPTH(OUT_LATENCY), .WIDTH($bits(tag_t))) u_tag (
      .clk   (clk),
      .rst_n (reset),
      .din   (tag_s),
      .dout  (tag_dly_s)
   );

   // Row counter: a pass change restarts numbering so the new block begins at row 0.
   always_comb begin
      rdy_d       = 1'b1;
      cnt_d       = cnt_q;
      last_pass_d = last_pass_q;
      row_idx_s   = cnt_q;
      tag_s       = '0;
      if (acc_s) begin
         if (in_pass != last_pass_q) begin
            row_idx_s = 3'd0;
         end else begin
            row_idx_s = cnt_q;
         end
         cnt_d       = row_idx_s + 3'd1;
         last_pass_d = in_pass;
         tag_s.valid = 1'b1;
         tag_s.row   = row_idx_s;
         tag_s.last  = (row_idx_s == 3'd7);
      end else begin
         cnt_d       = cnt_q;
         last_pass_d = last_pass_q;
      end
   end

   // Rounding pair for the slot reaching the output stage; bubbles get 0/0.
   always_comb begin
      add_d   = 25'd0;
      shift_d = 4'd0;
      out_d   = tag_dly_s;
      if (pass_dly_s[1]) begin
         add_d   = pass_add(pass_dly_s[0]);
         shift_d = pass_shift(pass_dly_s[0]);
      end else begin
         add_d   = 25'd0;
         shift_d = 4'd0;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_q       <= 1'b0;
         cnt_q       <= 3'd0;
         last_pass_q <= 1'b0;
         add_q       <= 25'd0;
         shift_q     <= 4'd0;
         out_q       <= '0;
      end else begin
         rdy_q       <= rdy_d;
         cnt_q       <= cnt_d;
         last_pass_q <= last_pass_d;
         add_q       <= add_d;
         shift_q     <= shift_d;
         out_q       <= out_d;
      end
   end

   assign in_ready  = rdy_q;
   assign add       = add_q;
   assign shift     = shift_q;
   assign out_valid = out_q.valid;
   assign out_row   = out_q.row;
   assign out_last  = out_q.last;

   assign d_in_1 = lane_out_s[0];
   assign d_in_2 = lane_out_s[1];
   assign d_in_3 = lane_out_s[2];
   assign d_in_4 = lane_out_s[3];
   assign d_in_5 = lane_out_s[4];
   assign d_in_6 = lane_out_s[5];
   assign d_in_7 = lane_out_s[6];
   assign d_in_8 = lane_out_s[7];

endmodule

// File: tb/tb_idct8_skew_feeder.sv
// Directed bench for idct8_skew_feeder: rows are listed as slot tables with
// hand-assigned row tags; lane/constant/tag expectations follow the skew timing.
module tb_idct8_skew_feeder;

   import idct_pkg::*;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_pass = 1'b0;
   logic                in_ready;
   logic signed [W-1:0] in_row [8];
   logic signed [W-1:0] d_in [8];
   logic [24:0]         add;
   logic [3:0]          shift;
   logic                out_valid;
   logic [2:0]          out_row;
   logic                out_last;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic       v;
      logic       p;
      int         base;
      int         step;
      logic [2:0] row;
   } slot_t;

   slot_t sl [16];

   idct8_skew_feeder dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pass(in_pass),
      .in_row_1(in_row[0]), .in_row_2(in_row[1]), .in_row_3(in_row[2]), .in_row_4(in_row[3]),
      .in_row_5(in_row[4]), .in_row_6(in_row[5]), .in_row_7(in_row[6]), .in_row_8(in_row[7]),
      .d_in_1(d_in[0]), .d_in_2(d_in[1]), .d_in_3(d_in[2]), .d_in_4(d_in[3]),
      .d_in_5(d_in[4]), .d_in_6(d_in[5]), .d_in_7(d_in[6]), .d_in_8(d_in[7]),
      .add(add), .shift(shift), .out_valid(out_valid), .out_row(out_row), .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      for (int k = 0; k < 8; k++) begin
         check_val($sformatf("%s d_in_%0d", tag, k + 1), d_in[k], '0);
      end
      check_val({tag, " add"}, add, 64'd0);
      check_val({tag, " shift"}, shift, 64'd0);
      check_val({tag, " out_valid"}, out_valid, 64'd0);
      check_val({tag, " out_row"}, out_row, 64'd0);
      check_val({tag, " out_last"}, out_last, 64'd0);
   endtask

   task automatic set_slot(input int i, input logic v, input logic p, input int base,
                           input int step, input logic [2:0] row);
      sl[i].v    = v;
      sl[i].p    = p;
      sl[i].base = base;
      sl[i].step = step;
      sl[i].row  = row;
   endtask

   // Bubble slots still present junk data so that gating by accept is exercised.
   task automatic drive_slot(input int i, input int n);
      if (i < n && sl[i].v) begin
         in_valid = 1'b1;
         in_pass  = sl[i].p;
         for (int k = 0; k < 8; k++) in_row[k] = W'(sl[i].base + sl[i].step * (k + 1));
      end else begin
         in_valid = 1'b0;
         in_pass  = 1'b1;
         for (int k = 0; k < 8; k++) in_row[k] = W'(32'h0001_ABC0 + k);
      end
   endtask

   // Observation j is taken after edge A0+j, A0 being the edge accepting slot 0.
   task automatic run_slots(input string name, input int n);
      logic signed [W-1:0] e;
      int idx;
      for (int j = -1; j < n + 10; j++) begin
         if (j >= 0) begin
            check_val($sformatf("%s j%0d in_ready", name, j), in_ready, 64'd1);
            for (int k = 0; k < 8; k++) begin
               idx = j - k;
               if (idx >= 0 && idx < n && sl[idx].v) e = W'(sl[idx].base + sl[idx].step * (k + 1));
               else e = '0;
               check_val($sformatf("%s j%0d d_in_%0d", name, j, k + 1), d_in[k], e);
            end
            idx = j - 8;
            if (idx >= 0 && idx < n && sl[idx].v) begin
               check_val($sformatf("%s j%0d add", name, j), add, sl[idx].p ? 64'd2048 : 64'd64);
               check_val($sformatf("%s j%0d shift", name, j), shift, sl[idx].p ? 64'd12 : 64'd7);
            end else begin
               check_val($sformatf("%s j%0d add", name, j), add, 64'd0);
               check_val($sformatf("%s j%0d shift", name, j), shift, 64'd0);
            end
            idx = j - 9;
            if (idx >= 0 && idx < n && sl[idx].v) begin
               check_val($sformatf("%s j%0d out_valid", name, j), out_valid, 64'd1);
               check_val($sformatf("%s j%0d out_row", name, j), out_row, 64'(sl[idx].row));
               check_val($sformatf("%s j%0d out_last", name, j), out_last,
                         (sl[idx].row == 3'd7) ? 64'd1 : 64'd0);
            end else begin
               check_val($sformatf("%s j%0d out_valid", name, j), out_valid, 64'd0);
               check_val($sformatf("%s j%0d out_row", name, j), out_row, 64'd0);
               check_val($sformatf("%s j%0d out_last", name, j), out_last, 64'd0);
            end
         end
         drive_slot(j + 1, n);
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 8; k++) in_row[k] = '0;

      // Reset release: in_ready low one cycle, outputs idle.
      repeat (3) @(negedge clk);
      check_val("rst in_ready", in_ready, 64'd0);
      check_idle("rst");
      reset = 1'b1;
      #1;
      check_val("rel in_ready first cycle", in_ready, 64'd0);
      @(negedge clk);
      check_val("rel in_ready", in_ready, 64'd1);
      check_idle("rel");
      repeat (2) begin
         @(negedge clk);
         check_idle("pre-accept");
      end

      // Single pass-0 row 10..80.
      set_slot(0, 1'b1, 1'b0, 0, 10, 3'd0);
      run_slots("single", 1);

      // Nine back-to-back pass-1 rows; the ninth wraps the counter to 0.
      for (int i = 0; i < 9; i++) set_slot(i, 1'b1, 1'b1, 100 * i, 1, 3'(i % 8));
      run_slots("burst", 9);

      // Pass 0 then pass 1 on consecutive cycles: both restart at row 0.
      set_slot(0, 1'b1, 1'b0, 5000, 1, 3'd0);
      set_slot(1, 1'b1, 1'b1, -5000, -1, 3'd0);
      run_slots("passchg", 2);

      // Row, three bubbles, row (negative coefficients on the second).
      set_slot(0, 1'b1, 1'b0, 7, 2, 3'd0);
      set_slot(1, 1'b0, 1'b0, 0, 0, 3'd0);
      set_slot(2, 1'b0, 1'b0, 0, 0, 3'd0);
      set_slot(3, 1'b0, 1'b0, 0, 0, 3'd0);
      set_slot(4, 1'b1, 1'b0, -70, -10, 3'd1);
      run_slots("bubble", 5);

      // Reset pulsed with a row in flight.
      set_slot(0, 1'b1, 1'b0, 0, 1, 3'd0);
      drive_slot(0, 1);
      @(negedge clk);
      drive_slot(1, 1);
      repeat (3) @(negedge clk);
      check_val("inflight d_in_4", d_in[3], 64'd4);
      #2;
      reset = 1'b0;
      #1;
      check_val("async rst in_ready", in_ready, 64'd0);
      check_idle("async rst");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      check_val("rerel in_ready first cycle", in_ready, 64'd0);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         check_val($sformatf("post rst c%0d in_ready", c), in_ready, 64'd1);
         check_idle($sformatf("post rst c%0d", c));
      end
      set_slot(0, 1'b1, 1'b1, 300, 3, 3'd0);
      run_slots("resume", 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
